// File: rtl/obc_shift_accumulator_if.sv
// Handshake and data bundle between the OBC shift-accumulator and its neighbours:
// the upstream bit slicer / ROM-sum stage, the frame requester and the result consumer.
// master: environment side (drives start, romout, y_ready).
// slave:  accumulator side (drives sequencing controls and the result).
interface obc_shift_accumulator_if #(
    parameter int unsigned ROM_W  = 32,
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ACC_W  = 48
);
    localparam int unsigned IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    logic                    start;
    logic                    start_ready;
    logic signed [ROM_W-1:0] romout;
    logic [IDX_W-1:0]        bit_idx;
    logic                    inv_o;
    logic                    busy;
    logic signed [ACC_W-1:0] y;
    logic                    y_valid;
    logic                    y_ready;

    modport master (
        output start,
        output romout,
        output y_ready,
        input  start_ready,
        input  bit_idx,
        input  inv_o,
        input  busy,
        input  y,
        input  y_valid
    );

    modport slave (
        input  start,
        input  romout,
        input  y_ready,
        output start_ready,
        output bit_idx,
        output inv_o,
        output busy,
        output y,
        output y_valid
    );
endinterface

// File: rtl/obc_shift_accumulator.sv
// Bit-serial sequencer and shift-accumulator behind the OBC ROM-sum stage.
// Drives slice index / sign-slice invert upstream (LSB first), accumulates the
// returned partial sums weighted by 2^k, then emits ((acc >>> 1) + OFFSET) on a
// valid/ready handshake.
// Optional macro OBC_ROM_REG_EN: registers romout and its slice index one stage
// ahead of the adder; ACC stretches by one drain cycle and the result by one cycle.
module obc_shift_accumulator #(
    parameter int unsigned ROM_W  = 32,
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ACC_W  = 48,
    parameter int          OFFSET = 0
) (
    input logic                    clk,
    input logic                    rst_n,
    obc_shift_accumulator_if.slave bus
);
    localparam int unsigned IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);
    localparam logic signed [ACC_W-1:0] OFFSET_EXT = ACC_W'(OFFSET);

    typedef enum logic [1:0] {StIdle, StAcc, StDone} state_e;

    state_e                  state_q;
    logic [IDX_W-1:0]        bit_idx_q;
    logic                    inv_q;
    logic signed [ACC_W-1:0] acc_q;
    logic signed [ACC_W-1:0] y_q;
    logic                    y_valid_q;

    logic [IDX_W-1:0]        add_idx;
    logic signed [ACC_W-1:0] addend;
    logic signed [ACC_W-1:0] acc_next;
    logic signed [ACC_W-1:0] y_next;

`ifdef OBC_ROM_REG_EN
    logic signed [ROM_W-1:0] rom_q;
    logic [IDX_W-1:0]        rom_idx_q;
    logic                    rom_vld_q;
    // Set once every slice has been issued; the last one is still in rom_q.
    logic                    drain_q;
`endif

    // Weighted partial sum for this cycle; slice 0 restarts the accumulator.
    always_comb begin
`ifdef OBC_ROM_REG_EN
        add_idx = rom_idx_q;
        addend  = ACC_W'(rom_q);
`else
        add_idx = bit_idx_q;
        addend  = ACC_W'($signed(bus.romout));
`endif
        addend   = addend <<< add_idx;
        acc_next = ((add_idx == '0) ? '0 : acc_q) + addend;
        y_next   = (acc_next >>> 1) + OFFSET_EXT;
    end

    // Sequencer FSM, accumulator and registered result.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            bit_idx_q <= '0;
            inv_q     <= 1'b0;
            acc_q     <= '0;
            y_q       <= '0;
            y_valid_q <= 1'b0;
`ifdef OBC_ROM_REG_EN
            rom_q     <= '0;
            rom_idx_q <= '0;
            rom_vld_q <= 1'b0;
            drain_q   <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.start) begin
                        state_q   <= StAcc;
                        bit_idx_q <= '0;
                        inv_q     <= (LAST_IDX == '0);
`ifdef OBC_ROM_REG_EN
                        rom_vld_q <= 1'b0;
                        drain_q   <= 1'b0;
`endif
                    end
                end
                StAcc: begin
`ifdef OBC_ROM_REG_EN
                    if (!drain_q) begin
                        rom_q     <= $signed(bus.romout);
                        rom_idx_q <= bit_idx_q;
                        rom_vld_q <= 1'b1;
                        if (bit_idx_q == LAST_IDX) begin
                            drain_q   <= 1'b1;
                            bit_idx_q <= '0;
                            inv_q     <= 1'b0;
                        end else begin
                            bit_idx_q <= bit_idx_q + 1'b1;
                            inv_q     <= ((bit_idx_q + 1'b1) == LAST_IDX);
                        end
                    end else begin
                        rom_vld_q <= 1'b0;
                        drain_q   <= 1'b0;
                        state_q   <= StDone;
                        y_q       <= y_next;
                        y_valid_q <= 1'b1;
                    end
                    if (rom_vld_q) begin
                        acc_q <= acc_next;
                    end
`else
                    acc_q <= acc_next;
                    if (bit_idx_q == LAST_IDX) begin
                        state_q   <= StDone;
                        bit_idx_q <= '0;
                        inv_q     <= 1'b0;
                        y_q       <= y_next;
                        y_valid_q <= 1'b1;
                    end else begin
                        bit_idx_q <= bit_idx_q + 1'b1;
                        inv_q     <= ((bit_idx_q + 1'b1) == LAST_IDX);
                    end
`endif
                end
                StDone: begin
                    // start is ignored here; only the result handshake completes.
                    if (bus.y_ready) begin
                        y_valid_q <= 1'b0;
                        state_q   <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.start_ready = (state_q == StIdle);
    assign bus.busy        = (state_q == StAcc);
    assign bus.bit_idx     = bit_idx_q;
    assign bus.inv_o       = inv_q;
    assign bus.y           = y_q;
    assign bus.y_valid     = y_valid_q;
endmodule

// File: tb/tb_obc_shift_accumulator.sv
// Bench for obc_shift_accumulator: two instances (OFFSET 0 and 100) share all
// stimulus; a behavioural upstream model returns romout from a per-frame
// slice table, and expected results come from a plain weighted-sum model.
module tb_obc_shift_accumulator;
    localparam int ROM_W  = 32;
    localparam int DATA_W = 16;
    localparam int ACC_W  = 48;
`ifdef OBC_ROM_REG_EN
    localparam int LAT = DATA_W + 2;
`else
    localparam int LAT = DATA_W + 1;
`endif
    localparam int PERIOD = LAT + 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    logic signed [ROM_W-1:0] pat [DATA_W];

    obc_shift_accumulator_if #(.ROM_W(ROM_W), .DATA_W(DATA_W), .ACC_W(ACC_W)) bus0 ();
    obc_shift_accumulator_if #(.ROM_W(ROM_W), .DATA_W(DATA_W), .ACC_W(ACC_W)) bus1 ();

    obc_shift_accumulator #(.ROM_W(ROM_W), .DATA_W(DATA_W), .ACC_W(ACC_W), .OFFSET(0)) dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0.slave)
    );
    obc_shift_accumulator #(.ROM_W(ROM_W), .DATA_W(DATA_W), .ACC_W(ACC_W), .OFFSET(100)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1.slave)
    );

    always #5 clk = ~clk;

    assign bus1.start   = bus0.start;
    assign bus1.y_ready = bus0.y_ready;

    // Upstream ROM-sum stage: answers the requested slice, X when not accumulating.
    always_comb begin
        bus0.romout = 'x;
        if (bus0.busy) bus0.romout = pat[bus0.bit_idx];
    end
    always_comb begin
        bus1.romout = 'x;
        if (bus1.busy) bus1.romout = pat[bus1.bit_idx];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // y = floor(sum(pat[k] * 2^k) / 2) + off
    function automatic logic signed [ACC_W-1:0] model_y(input longint off);
        longint acc;
        acc = 0;
        for (int k = 0; k < DATA_W; k++) acc += longint'(pat[k]) * (longint'(1) << k);
        return ACC_W'((acc >>> 1) + off);
    endfunction

    task automatic fill(input int v);
        for (int k = 0; k < DATA_W; k++) pat[k] = ROM_W'(v);
    endtask

    // Start one frame from IDLE and stop in the first y_valid cycle.
    task automatic run_frame(output bit ok);
        ok = 1'b0;
        bus0.start = 1'b1;
        tick();
        bus0.start = 1'b0;
        for (int i = 0; i < 4 * PERIOD; i++) begin
            if (bus0.y_valid) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus0.start = 1'b0;
        bus0.y_ready = 1'b0;
        fill(0);
        tick();
        tick();
        checks++;
        if (bus0.start_ready !== 1'b1 || bus0.busy !== 1'b0 || bus0.bit_idx !== '0 ||
            bus0.inv_o !== 1'b0 || bus0.y_valid !== 1'b0 || bus0.y !== '0) begin
            errors++;
            $display("FAIL reset_state: got rdy=%b busy=%b idx=%0d inv=%b vld=%b y=%0d want 1 0 0 0 0 0",
                     bus0.start_ready, bus0.busy, bus0.bit_idx, bus0.inv_o, bus0.y_valid, bus0.y);
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if (bus0.start_ready !== 1'b1 || bus0.busy !== 1'b0 || bus1.y !== '0) begin
            errors++;
            $display("FAIL reset_release: got rdy=%b busy=%b y1=%0d want 1 0 0",
                     bus0.start_ready, bus0.busy, bus1.y);
        end
    endtask

    task automatic test_frame_timing();
        logic signed [ACC_W-1:0] e0, e1;
        fill(1);
        e0 = model_y(0);
        e1 = model_y(100);
        bus0.y_ready = 1'b1;
        bus0.start = 1'b1;
        tick();
        bus0.start = 1'b0;
        for (int c = 1; c <= LAT; c++) begin
            checks++;
            if (bus0.busy !== (c < LAT) || bus0.bit_idx !== 4'((c <= DATA_W) ? c - 1 : 0) ||
                bus0.inv_o !== (c == DATA_W) || bus0.y_valid !== (c == LAT) ||
                bus0.start_ready !== 1'b0) begin
                errors++;
                $display("FAIL timing_cycle%0d: got busy=%b idx=%0d inv=%b vld=%b rdy=%b want %b %0d %b %b 0",
                         c, bus0.busy, bus0.bit_idx, bus0.inv_o, bus0.y_valid, bus0.start_ready,
                         c < LAT, (c <= DATA_W) ? c - 1 : 0, c == DATA_W, c == LAT);
            end
            if (c == LAT) begin
                checks++;
                if (bus0.y !== e0 || bus1.y !== e1) begin
                    errors++;
                    $display("FAIL timing_result: got y0=%0d y1=%0d want %0d %0d", bus0.y, bus1.y, e0, e1);
                end
            end
            tick();
        end
        checks++;
        if (bus0.start_ready !== 1'b1 || bus0.y_valid !== 1'b0) begin
            errors++;
            $display("FAIL timing_back_idle: got rdy=%b vld=%b want 1 0", bus0.start_ready, bus0.y_valid);
        end
    endtask

    task automatic test_sign_slice();
        bit ok;
        fill(0);
        pat[DATA_W-1] = -2;
        bus0.y_ready = 1'b1;
        run_frame(ok);
        checks++;
        if (!ok || bus0.y !== -48'sd32768 || bus1.y !== -48'sd32668) begin
            errors++;
            $display("FAIL sign_slice: got ok=%b y0=%0d y1=%0d want 1 -32768 -32668", ok, bus0.y, bus1.y);
        end
        tick();
    endtask

    task automatic test_random();
        bit ok;
        logic signed [ACC_W-1:0] e0, e1;
        bus0.y_ready = 1'b1;
        for (int f = 0; f < 6; f++) begin
            for (int k = 0; k < DATA_W; k++) pat[k] = ROM_W'($urandom);
            e0 = model_y(0);
            e1 = model_y(100);
            run_frame(ok);
            checks++;
            if (!ok || bus0.y !== e0 || bus1.y !== e1) begin
                errors++;
                $display("FAIL random_frame%0d: got ok=%b y0=%0d y1=%0d want 1 %0d %0d",
                         f, ok, bus0.y, bus1.y, e0, e1);
            end
            tick();
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        logic signed [ACC_W-1:0] e0;
        for (int k = 0; k < DATA_W; k++) pat[k] = ROM_W'($urandom_range(0, 1000)) - 500;
        e0 = model_y(0);
        bus0.y_ready = 1'b0;
        run_frame(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL bp_first_valid: got no y_valid want y_valid within %0d cycles", 4 * PERIOD);
        end
        for (int i = 0; i < 5; i++) begin
            bus0.start = 1'b1;
            checks++;
            if (bus0.y_valid !== 1'b1 || bus0.y !== e0 || bus0.busy !== 1'b0 ||
                bus0.start_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold%0d: got vld=%b y=%0d busy=%b rdy=%b want 1 %0d 0 0",
                         i, bus0.y_valid, bus0.y, bus0.busy, bus0.start_ready, e0);
            end
            tick();
        end
        bus0.y_ready = 1'b1;
        tick();
        checks++;
        if (bus0.y_valid !== 1'b0 || bus0.start_ready !== 1'b1 || bus0.busy !== 1'b0 ||
            bus0.y !== e0) begin
            errors++;
            $display("FAIL bp_handshake: got vld=%b rdy=%b busy=%b y=%0d want 0 1 0 %0d",
                     bus0.y_valid, bus0.start_ready, bus0.busy, bus0.y, e0);
        end
        tick();
        bus0.start = 1'b0;
        checks++;
        if (bus0.busy !== 1'b1 || bus0.bit_idx !== '0) begin
            errors++;
            $display("FAIL bp_restart: got busy=%b idx=%0d want 1 0", bus0.busy, bus0.bit_idx);
        end
        ok = 1'b0;
        for (int i = 0; i < 4 * PERIOD; i++) begin
            if (bus0.y_valid) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        checks++;
        if (!ok || bus0.y !== e0) begin
            errors++;
            $display("FAIL bp_second_frame: got ok=%b y=%0d want 1 %0d", ok, bus0.y, e0);
        end
        tick();
    endtask

    task automatic test_reset_mid_frame();
        bit ok;
        fill(1);
        bus0.y_ready = 1'b1;
        bus0.start = 1'b1;
        tick();
        bus0.start = 1'b0;
        for (int i = 0; i < DATA_W && bus0.bit_idx != 4'd7; i++) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checks++;
        if (bus0.start_ready !== 1'b1 || bus0.busy !== 1'b0 || bus0.bit_idx !== '0 ||
            bus0.inv_o !== 1'b0 || bus0.y_valid !== 1'b0 || bus0.y !== '0) begin
            errors++;
            $display("FAIL midreset_state: got rdy=%b busy=%b idx=%0d inv=%b vld=%b y=%0d want 1 0 0 0 0 0",
                     bus0.start_ready, bus0.busy, bus0.bit_idx, bus0.inv_o, bus0.y_valid, bus0.y);
        end
        fill(3);
        run_frame(ok);
        checks++;
        if (!ok || bus0.y !== 48'sd98302 || bus1.y !== 48'sd98402) begin
            errors++;
            $display("FAIL midreset_frame: got ok=%b y0=%0d y1=%0d want 1 98302 98402", ok, bus0.y, bus1.y);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        int n, last, cur;
        logic signed [ACC_W-1:0] e0, e1;
        n = 0;
        last = -1;
        cur = 0;
        fill(1);
        bus0.y_ready = 1'b1;
        bus0.start = 1'b1;
        for (int cyc = 0; cyc < 8 * PERIOD && n < 4; cyc++) begin
            tick();
            if (bus0.y_valid) begin
                e0 = model_y(0);
                e1 = model_y(100);
                checks++;
                if (bus0.y !== e0 || bus1.y !== e1 || bus0.y !== ((cur == 0) ? 48'sd32767 : -48'sd32768)) begin
                    errors++;
                    $display("FAIL b2b_result%0d: got y0=%0d y1=%0d want %0d %0d", n, bus0.y, bus1.y, e0, e1);
                end
                if (last >= 0) begin
                    checks++;
                    if (cyc - last != PERIOD) begin
                        errors++;
                        $display("FAIL b2b_interval%0d: got %0d cycles want %0d", n, cyc - last, PERIOD);
                    end
                end
                last = cyc;
                n++;
                cur ^= 1;
                fill((cur == 0) ? 1 : -1);
                if (n == 4) bus0.start = 1'b0;
            end
        end
        checks++;
        if (n != 4) begin
            errors++;
            $display("FAIL b2b_count: got %0d results want 4", n);
        end
        bus0.start = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_frame_timing();
        test_sign_slice();
        test_random();
        test_backpressure();
        test_reset_mid_frame();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
